// File: rtl/i2c_resp_pkg.sv
// Shared types and helpers for the I2C register-file target.
package i2c_resp_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WR,
        S_WR_ACK,
        S_RD,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    function automatic logic is_start(input logic scl, input logic sda_fall);
        return scl & sda_fall;
    endfunction

    function automatic logic is_stop(input logic scl, input logic sda_rise);
        return scl & sda_rise;
    endfunction

endpackage

// File: rtl/i2c_resp_sync.sv
// Two-flop synchronizer plus history flop for SCL/SDA.
// Produces synchronized levels and one-cycle rise/fall strobes.
module i2c_resp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_rise,
    output logic sda_fall
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Reset to the idle bus level so no edge is seen on release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_raw};
            sda_q <= {sda_q[1:0], sda_raw};
        end
    end

    assign scl      = scl_q[1];
    assign sda      = sda_q[1];
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign sda_rise = sda_q[1] & ~sda_q[2];
    assign sda_fall = ~sda_q[1] & sda_q[2];

endmodule

// File: rtl/i2c_target_resp.sv
// I2C target with a pointer-addressed register file.
// Write sets the pointer then stores bytes; read streams bytes from the pointer.
module i2c_target_resp
    import i2c_resp_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR = 7'h22,
    parameter int         DEPTH    = 16,
    localparam int        PTR_W    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_o,
    output logic             busy_o,
    output logic             rx_valid_o,
    output logic [7:0]       rx_data_o,
    output logic [PTR_W-1:0] rx_ptr_o,
    output logic             stop_o
);

    logic scl;
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic sda_rise;
    logic sda_fall;

    i2c_resp_sync u_sync (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .scl_raw  (scl_i),
        .sda_raw  (sda_i),
        .scl      (scl),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_rise (sda_rise),
        .sda_fall (sda_fall)
    );

    logic start_det;
    logic stop_det;

    assign start_det = is_start(scl, sda_fall);
    assign stop_det  = is_stop(scl, sda_rise);

    state_t           state;
    logic [7:0]       sh;
    logic [2:0]       cnt;
    logic             full;
    logic             rw;
    logic             ack;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       mem [DEPTH];
    logic [7:0]       rd_byte;

    assign rd_byte = mem[ptr];

    // full marks 8 bits shifted; the byte is acted on at the next SCL fall
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            sh         <= '0;
            cnt        <= '0;
            full       <= 1'b0;
            rw         <= 1'b0;
            ack        <= I2C_NACK;
            ptr        <= '0;
            sda_o      <= 1'b1;
            busy_o     <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            rx_ptr_o   <= '0;
            stop_o     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rx_valid_o <= 1'b0;
            stop_o     <= 1'b0;
            priority case (1'b1)
                start_det: begin
                    state <= S_ADDR;
                    cnt   <= '0;
                    full  <= 1'b0;
                    sda_o <= 1'b1;
                end
                stop_det: begin
                    state  <= S_IDLE;
                    cnt    <= '0;
                    full   <= 1'b0;
                    sda_o  <= 1'b1;
                    busy_o <= 1'b0;
                    stop_o <= 1'b1;
                end
                scl_rise: begin
                    unique case (state)
                        S_ADDR, S_PTR, S_WR: begin
                            sh  <= {sh[6:0], sda};
                            cnt <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                full <= 1'b1;
                            end
                        end
                        S_RD_ACK: begin
                            ack  <= sda;
                            ptr  <= ptr + PTR_W'(1);
                            full <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                scl_fall: begin
                    unique case (state)
                        S_ADDR: begin
                            if (full) begin
                                full <= 1'b0;
                                if (sh[7:1] == TGT_ADDR) begin
                                    state  <= S_ADDR_ACK;
                                    sda_o  <= I2C_ACK;
                                    busy_o <= 1'b1;
                                    rw     <= sh[0];
                                end else begin
                                    state  <= S_WAIT_STOP;
                                    sda_o  <= 1'b1;
                                    busy_o <= 1'b0;
                                end
                            end
                        end
                        S_ADDR_ACK: begin
                            if (rw) begin
                                state <= S_RD;
                                sda_o <= rd_byte[7];
                                sh    <= {rd_byte[6:0], 1'b0};
                                cnt   <= 3'd1;
                            end else begin
                                state <= S_PTR;
                                sda_o <= 1'b1;
                                cnt   <= '0;
                            end
                        end
                        S_PTR: begin
                            if (full) begin
                                full  <= 1'b0;
                                ptr   <= sh[PTR_W-1:0];
                                sda_o <= I2C_ACK;
                                state <= S_PTR_ACK;
                            end
                        end
                        S_PTR_ACK, S_WR_ACK: begin
                            sda_o <= 1'b1;
                            cnt   <= '0;
                            state <= S_WR;
                        end
                        S_WR: begin
                            if (full) begin
                                full       <= 1'b0;
                                mem[ptr]   <= sh;
                                rx_valid_o <= 1'b1;
                                rx_data_o  <= sh;
                                rx_ptr_o   <= ptr;
                                ptr        <= ptr + PTR_W'(1);
                                sda_o      <= I2C_ACK;
                                state      <= S_WR_ACK;
                            end
                        end
                        S_RD: begin
                            // cnt wraps to 0 once the 8th bit has been put out
                            if (cnt == 3'd0) begin
                                sda_o <= 1'b1;
                                full  <= 1'b0;
                                state <= S_RD_ACK;
                            end else begin
                                sda_o <= sh[7];
                                sh    <= {sh[6:0], 1'b0};
                                cnt   <= cnt + 3'd1;
                            end
                        end
                        S_RD_ACK: begin
                            if (full) begin
                                full <= 1'b0;
                                if (ack == I2C_NACK) begin
                                    sda_o <= 1'b1;
                                    state <= S_WAIT_STOP;
                                end else begin
                                    state <= S_RD;
                                    sda_o <= rd_byte[7];
                                    sh    <= {rd_byte[6:0], 1'b0};
                                    cnt   <= 3'd1;
                                end
                            end
                        end
                        default: begin
                            sda_o <= 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
